// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one read/write INCR burst outstanding at a time.
// Optional response/length checking via BURST_MASTER_ERR_CHECK_EN.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 10,
  parameter int AXI_ID     = 0
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  done_q, done_d;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AX_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AX_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign rd_data     = m_axi_rdata;
  assign rd_last     = m_axi_rlast;
  assign done        = done_q;

  // Burst sequencing: next state, beat counter and handshake outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    done_d        = 1'b0;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    rd_valid      = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Hold off the next command during the done pulse.
        cmd_ready = ~done_q;
        if (cmd_valid && !done_q) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 8'd0;
          state_d = cmd_write ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == len_q);
        if (wr_valid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (m_axi_rvalid && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (m_axi_rlast) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and command registers.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

`ifdef BURST_MASTER_ERR_CHECK_EN
  logic err_q, err_d;
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Sticky error on bad responses or a burst-length mismatch at rlast.
  always_comb begin
    err_d = err_q;
    if (state_q == S_WR_RESP && m_axi_bvalid && m_axi_bresp != 2'b00)
      err_d = 1'b1;
    if (state_q == S_RD_DATA && m_axi_rvalid && rd_ready) begin
      if (m_axi_rresp != 2'b00) err_d = 1'b1;
      if (m_axi_rlast && cnt_q != len_q) err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{m_axi_bid, m_axi_rid, m_axi_bresp, m_axi_rresp};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Testbench for axi_burst_master: directed bursts checked
// against a transaction-level model every cycle.
module tb_axi_burst_master;

`ifdef BURST_MASTER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        aclk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [18:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done, err;
  logic [9:0]  m_axi_awid;
  logic [18:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [9:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [9:0]  m_axi_arid;
  logic [18:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [9:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master dut (
    .aclk(aclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Transaction model state
  logic [35:0] wq[$];
  logic [32:0] rq[$];
  int          phase    = 0;
  int          nbeat    = 0;
  bit          done_due = 1'b0;
  bit          exp_err  = 1'b0;
  logic [18:0] exp_addr = '0;
  logic [7:0]  exp_len  = '0;

  // Observed history for literal checks
  int          done_cnt  = 0;
  int          w_hs_cnt  = 0;
  int          wlast_cnt = 0;
  int          r_hs_cnt  = 0;
  logic [18:0] last_awaddr;
  logic [7:0]  last_awlen;
  logic [31:0] last_wlast_data;
  logic [31:0] last_rd_data;
  logic        last_rd_last;

  // Per-cycle compare against the phase-level model
  always @(negedge aclk) begin
    logic [35:0] we;
    logic [32:0] re;
    if (reset) begin
      phase    = 0;
      done_due = 1'b0;
      exp_err  = 1'b0;
      wq.delete();
      rq.delete();
    end else begin
      chk("cmd_ready", cmd_ready, (phase == 0) && !done_due);
      chk("done", done, done_due);
      chk("err", err, exp_err);
      if (done) done_cnt++;
      done_due = 1'b0;
      case (phase)
        0: begin
          chk("idle_quiet",
              {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
               m_axi_arvalid, m_axi_rready, wr_ready, rd_valid}, 0);
          if (cmd_valid && cmd_ready) begin
            exp_addr = cmd_addr;
            exp_len  = cmd_len;
            nbeat    = 0;
            phase    = cmd_write ? 1 : 4;
          end
        end
        1: begin
          chk("aw_phase",
              {m_axi_awvalid, m_axi_wvalid, wr_ready,
               m_axi_bready, m_axi_arvalid}, 5'b10000);
          chk("aw_fields",
              {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
               m_axi_awburst, m_axi_awlock, m_axi_awcache,
               m_axi_awprot},
              {10'd0, exp_addr, exp_len, 3'd2, 2'b01,
               1'b0, 4'd0, 3'd0});
          if (m_axi_awvalid && m_axi_awready) begin
            last_awaddr = m_axi_awaddr;
            last_awlen  = m_axi_awlen;
            phase       = 2;
          end
        end
        2: begin
          chk("w_phase",
              {m_axi_awvalid, m_axi_wvalid, wr_ready,
               m_axi_bready, m_axi_arvalid},
              {1'b0, wr_valid, m_axi_wready, 2'b00});
          if (m_axi_wvalid && m_axi_wready) begin
            w_hs_cnt++;
            if (m_axi_wlast) begin
              wlast_cnt++;
              last_wlast_data = m_axi_wdata;
            end
            if (wq.size() == 0) begin
              chk("w_extra_beat", 1, 0);
            end else begin
              we = wq.pop_front();
              chk("w_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast},
                  {we, nbeat == int'(exp_len)});
            end
            if (nbeat == int'(exp_len)) phase = 3;
            nbeat++;
          end
        end
        3: begin
          chk("b_phase",
              {m_axi_awvalid, m_axi_wvalid, wr_ready,
               m_axi_bready, m_axi_arvalid}, 5'b00010);
          if (m_axi_bvalid) begin
            if (ERR_EN && m_axi_bresp != 2'b00) exp_err = 1'b1;
            phase    = 0;
            done_due = 1'b1;
          end
        end
        4: begin
          chk("ar_phase",
              {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
               m_axi_arvalid, m_axi_rready, rd_valid, wr_ready},
              7'b0001000);
          chk("ar_fields",
              {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
               m_axi_arburst, m_axi_arlock, m_axi_arcache,
               m_axi_arprot},
              {10'd0, exp_addr, exp_len, 3'd2, 2'b01,
               1'b0, 4'd0, 3'd0});
          if (m_axi_arvalid && m_axi_arready) phase = 5;
        end
        5: begin
          chk("r_phase",
              {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
               m_axi_arvalid, wr_ready, rd_valid, m_axi_rready},
              {5'b00000, m_axi_rvalid, rd_ready});
          if (m_axi_rvalid)
            chk("r_pass", {rd_data, rd_last},
                {m_axi_rdata, m_axi_rlast});
          if (m_axi_rvalid && m_axi_rready) begin
            r_hs_cnt++;
            last_rd_data = rd_data;
            last_rd_last = rd_last;
            if (rq.size() == 0) begin
              chk("r_extra_beat", 1, 0);
            end else begin
              re = rq.pop_front();
              chk("r_beat", {rd_data, rd_last}, re);
            end
            if (ERR_EN && (m_axi_rresp != 2'b00 ||
                (m_axi_rlast && nbeat != int'(exp_len))))
              exp_err = 1'b1;
            nbeat++;
            if (m_axi_rlast) begin
              phase    = 0;
              done_due = 1'b1;
            end
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [18:0] a,
                          input logic [7:0] l);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 50) begin
      step();
      @(negedge aclk);
      n++;
    end
    chk("cmd_accept_timeout", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge aclk);
    while (!done && n < 20) begin
      step();
      @(negedge aclk);
      n++;
    end
    chk("done_timeout", done, 1);
    chk("done_blocks_cmd", cmd_ready, 0);
    step();
    @(negedge aclk);
    chk("ready_after_done", cmd_ready, 1);
    step();
  endtask

  task automatic write_burst(input logic [18:0] a, input int len,
                             input int awdly, input bit gap,
                             input logic [1:0] bresp,
                             input logic [31:0] base,
                             input int abort_after);
    int n;
    for (int i = 0; i <= len; i++)
      wq.push_back({base + 32'(i), 4'hF ^ 4'(i)});
    // Offer the first beat early; it must not be taken before AW.
    wr_valid = 1'b1;
    wr_data  = base;
    wr_strb  = 4'hF;
    send_cmd(1'b1, a, 8'(len));
    m_axi_awready = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!m_axi_awvalid && n < 50) begin
      step();
      @(negedge aclk);
      n++;
    end
    chk("aw_timeout", m_axi_awvalid, 1);
    repeat (awdly) begin
      step();
      @(negedge aclk);
    end
    step();
    m_axi_awready = 1'b1;
    @(negedge aclk);
    step();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b1;
    for (int i = 0; i <= len; i++) begin
      if (gap && (i % 3 == 1)) begin
        wr_valid = 1'b0;
        step();
      end
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      wr_strb  = 4'hF ^ 4'(i);
      n = 0;
      @(negedge aclk);
      while (!wr_ready && n < 50) begin
        step();
        @(negedge aclk);
        n++;
      end
      chk("w_timeout", wr_ready, 1);
      step();
      if (i == abort_after) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_valids",
            {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_arvalid, done, err}, 0);
        chk("rst_idle", cmd_ready, 1);
        wr_valid     = 1'b0;
        m_axi_wready = 1'b0;
        @(negedge aclk);
        step();
        #2 reset = 1'b0;
        step();
        return;
      end
    end
    wr_valid     = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp;
    n = 0;
    @(negedge aclk);
    while (!m_axi_bready && n < 50) begin
      step();
      @(negedge aclk);
      n++;
    end
    chk("b_timeout", m_axi_bready, 1);
    step();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    wait_done();
  endtask

  task automatic read_burst(input logic [18:0] a, input int len,
                            input int ardly, input bit tog,
                            input logic [31:0] base);
    int n;
    logic hs;
    for (int i = 0; i <= len; i++)
      rq.push_back({base + 32'(i) * 32'h11, i == len});
    // A stray write beat must never be acked during a read.
    wr_valid = 1'b1;
    send_cmd(1'b0, a, 8'(len));
    m_axi_arready = 1'b0;
    n = 0;
    @(negedge aclk);
    while (!m_axi_arvalid && n < 50) begin
      step();
      @(negedge aclk);
      n++;
    end
    chk("ar_timeout", m_axi_arvalid, 1);
    repeat (ardly) begin
      step();
      @(negedge aclk);
    end
    step();
    m_axi_arready = 1'b1;
    @(negedge aclk);
    step();
    m_axi_arready = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = base + 32'(i) * 32'h11;
      m_axi_rlast  = (i == len);
      n = 0;
      @(negedge aclk);
      hs = m_axi_rready;
      while (!hs && n < 50) begin
        step();
        if (tog) rd_ready = ~rd_ready;
        @(negedge aclk);
        hs = m_axi_rready;
        n++;
      end
      chk("r_timeout", hs, 1);
      step();
      if (tog) rd_ready = ~rd_ready;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    rd_ready     = 1'b1;
    wr_valid     = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, l0, r0;
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 1'b1;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    #23;
    chk("reset_outputs",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
         m_axi_arvalid, done, err}, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    step();
    reset = 1'b0;
    step();

    // Write len=3 with AW held off for two cycles
    d0 = done_cnt; w0 = w_hs_cnt; l0 = wlast_cnt;
    write_burst(19'h100, 3, 2, 1'b0, 2'b00, 32'hA0, -1);
    chk("t1_awaddr", last_awaddr, 19'h100);
    chk("t1_awlen", last_awlen, 3);
    chk("t1_beats", w_hs_cnt - w0, 4);
    chk("t1_wlast_cnt", wlast_cnt - l0, 1);
    chk("t1_wlast_data", last_wlast_data, 32'hA3);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // Single-beat read
    d0 = done_cnt; r0 = r_hs_cnt;
    read_burst(19'h40, 0, 0, 1'b0, 32'hDEADBEEF);
    chk("t2_rd_data", last_rd_data, 32'hDEADBEEF);
    chk("t2_rd_last", last_rd_last, 1);
    chk("t2_beats", r_hs_cnt - r0, 1);
    chk("t2_done_cnt", done_cnt - d0, 1);

    // Eight-beat read with rd_ready toggling
    d0 = done_cnt; r0 = r_hs_cnt;
    read_burst(19'h80, 7, 1, 1'b1, 32'h1000_0000);
    chk("t3_beats", r_hs_cnt - r0, 8);
    chk("t3_last_data", last_rd_data, 32'h1000_0077);
    chk("t3_queue_empty", rq.size(), 0);
    chk("t3_done_cnt", done_cnt - d0, 1);

    // Reset after the first beat of a write, then a clean write
    write_burst(19'h200, 3, 0, 1'b0, 2'b00, 32'hB0, 0);
    chk("t4_queue_cleared", wq.size(), 0);
    d0 = done_cnt; w0 = w_hs_cnt;
    write_burst(19'h300, 1, 1, 1'b0, 2'b00, 32'hC0, -1);
    chk("t4_awaddr", last_awaddr, 19'h300);
    chk("t4_beats", w_hs_cnt - w0, 2);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // Error response then an OK burst
    write_burst(19'h010, 0, 0, 1'b0, 2'b10, 32'hE0, -1);
    write_burst(19'h014, 0, 0, 1'b0, 2'b00, 32'hE1, -1);
    chk("t5_err_sticky", err, ERR_EN);

    // Maximum length write with wr_valid gaps
    d0 = done_cnt; w0 = w_hs_cnt; l0 = wlast_cnt;
    write_burst(19'h400, 255, 0, 1'b1, 2'b00, 32'h5000_0000, -1);
    chk("t6_beats", w_hs_cnt - w0, 256);
    chk("t6_wlast_cnt", wlast_cnt - l0, 1);
    chk("t6_wlast_data", last_wlast_data, 32'h5000_00FF);
    chk("t6_done_cnt", done_cnt - d0, 1);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
